// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite scanline buffer: one bank is filled by the sprite engine
// while the other is read out at pixel rate and cleared behind the read.
module sprite_line_buffer #(
    parameter int unsigned     DW          = 8,
    parameter int unsigned     LINE_WIDTH  = 288,
    parameter logic [DW-1:0]   TRANSPARENT = '0,
    parameter bit              FIRST_WINS  = 1'b1
) (
    input  logic          CLK_48M,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic          nHBLANK,
    input  logic          nVBLANK,
    input  logic          wr_en,
    input  logic [8:0]    wr_x,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [8:0]    rd_x,
    output logic          rd_bank,
    output logic          swap,
    output logic          wr_drop
);

    localparam int unsigned     XW     = 9;
    localparam logic [XW-1:0]   X_LAST = XW'(LINE_WIDTH - 1);
    localparam logic [XW-1:0]   X_LIM  = XW'(LINE_WIDTH);

    logic                       hblank_q;
    logic                       vblank_q;
    logic [1:0][LINE_WIDTH-1:0] occ;
    logic [DW-1:0]              mem [0:1][0:LINE_WIDTH-1];

    logic swap_c;
    logic read_c;
    logic in_range_c;
    logic wr_bank_c;
    logic wr_ok_c;
    logic wr_commit_c;
    logic rd_hit_c;

    // Event decode: swap on the sampled falling edge of nHBLANK, read while active.
    always_comb begin
        swap_c      = pix_ce & hblank_q & ~nHBLANK;
        read_c      = pix_ce & hblank_q & ~swap_c;
        in_range_c  = (wr_x < X_LIM);
        wr_bank_c   = ~rd_bank;
        wr_ok_c     = wr_en & in_range_c & (wr_data != TRANSPARENT) & ~swap_c;
        wr_commit_c = wr_ok_c & ~(FIRST_WINS & occ[wr_bank_c][wr_x]);
        rd_hit_c    = occ[rd_bank][rd_x] & vblank_q;
    end

    // Control state, occupancy and registered outputs.
    always_ff @(posedge CLK_48M or posedge rst) begin
        if (rst) begin
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            rd_data  <= TRANSPARENT;
            rd_valid <= 1'b0;
            rd_x     <= '0;
            rd_bank  <= 1'b0;
            swap     <= 1'b0;
            wr_drop  <= 1'b0;
            occ      <= '0;
        end else begin
            swap    <= swap_c;
            wr_drop <= wr_en & (~in_range_c | swap_c);
            if (pix_ce) begin
                hblank_q <= nHBLANK;
                vblank_q <= nVBLANK;
            end
            if (read_c) begin
                rd_valid           <= rd_hit_c;
                rd_data            <= rd_hit_c ? mem[rd_bank][rd_x] : TRANSPARENT;
                occ[rd_bank][rd_x] <= 1'b0;
                if (rd_x != X_LAST) begin
                    rd_x <= rd_x + XW'(1);
                end
            end else if (pix_ce) begin
                rd_data  <= TRANSPARENT;
                rd_valid <= 1'b0;
            end
            if (swap_c) begin
                rd_bank <= ~rd_bank;
                rd_x    <= '0;
            end
            // Read and write banks always differ, so both updates can land together.
            if (wr_commit_c) begin
                occ[wr_bank_c][wr_x] <= 1'b1;
            end
        end
    end

    // Pixel storage; validity is tracked solely by occ, so no reset is needed here.
    always_ff @(posedge CLK_48M) begin
        if (wr_commit_c) begin
            mem[wr_bank_c][wr_x] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Randomised and directed checks of sprite_line_buffer against a per-pixel line model.
module tb_sprite_line_buffer;

    localparam int LW = 288;

    logic       CLK_48M = 1'b0;
    logic       rst     = 1'b0;
    logic       pix_ce  = 1'b0;
    logic       nHBLANK = 1'b1;
    logic       nVBLANK = 1'b1;
    logic       wr_en   = 1'b0;
    logic [8:0] wr_x    = '0;
    logic [7:0] wr_data = '0;

    logic [7:0] rd_data,  rd_data_b;
    logic       rd_valid, rd_valid_b;
    logic [8:0] rd_x,     rd_x_b;
    logic       rd_bank,  rd_bank_b;
    logic       swap,     swap_b;
    logic       wr_drop,  wr_drop_b;

    sprite_line_buffer dut (
        .CLK_48M(CLK_48M), .rst(rst), .pix_ce(pix_ce), .nHBLANK(nHBLANK), .nVBLANK(nVBLANK),
        .wr_en(wr_en), .wr_x(wr_x), .wr_data(wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_x(rd_x), .rd_bank(rd_bank),
        .swap(swap), .wr_drop(wr_drop)
    );

    sprite_line_buffer #(.FIRST_WINS(1'b0)) dut_lw (
        .CLK_48M(CLK_48M), .rst(rst), .pix_ce(pix_ce), .nHBLANK(nHBLANK), .nVBLANK(nVBLANK),
        .wr_en(wr_en), .wr_x(wr_x), .wr_data(wr_data),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_x(rd_x_b), .rd_bank(rd_bank_b),
        .swap(swap_b), .wr_drop(wr_drop_b)
    );

    always #10 CLK_48M = ~CLK_48M;

    int checks   = 0;
    int failures = 0;

    // Line model: each pixel slot holds -1 when empty, else the stored palette index.
    int line_px [2][LW];
    int m_rb, m_rx, last_rd_x, exp_data, exp_valid;
    bit m_hq, m_vq;
    int exp_drops, exp_swaps, dut_drops, dut_swaps;

    int obs_d [LW];
    int obs_v [LW];
    int exp_d [LW];
    int exp_v [LW];
    int obs_b_d [LW];
    int obs_b_v [LW];
    bit rand_wr = 1'b0;
    bit pix_swap0, pix_bank0, pix_swap1;
    bit post_swap, post_bank, post_swap2;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int x = 0; x < LW; x++) line_px[b][x] = -1;
        m_rb = 0; m_rx = 0; m_hq = 1'b1; m_vq = 1'b1;
        exp_data = 0; exp_valid = 0; last_rd_x = -1;
        exp_drops = 0; exp_swaps = 0; dut_drops = 0; dut_swaps = 0;
    endtask

    task automatic model_step();
        bit sw;
        int x, wb;
        sw = pix_ce && m_hq && !nHBLANK;
        last_rd_x = -1;
        x = int'(wr_x);
        if (wr_en) begin
            if (x >= LW || sw) exp_drops++;
            else if (wr_data != 8'h00) begin
                wb = 1 - m_rb;
                if (line_px[wb][x] < 0) line_px[wb][x] = int'(wr_data);
            end
        end
        if (pix_ce) begin
            if (m_hq && !sw) begin
                last_rd_x = m_rx;
                if (line_px[m_rb][m_rx] >= 0 && m_vq) begin
                    exp_data = line_px[m_rb][m_rx]; exp_valid = 1;
                end else begin
                    exp_data = 0; exp_valid = 0;
                end
                line_px[m_rb][m_rx] = -1;
                if (m_rx < LW - 1) m_rx++;
            end else begin
                exp_data = 0; exp_valid = 0;
            end
            if (sw) begin
                m_rb = 1 - m_rb; m_rx = 0; exp_swaps++;
            end
            m_hq = nHBLANK; m_vq = nVBLANK;
        end
    endtask

    task automatic tick();
        if (!rst) model_step();
        @(posedge CLK_48M);
        #1;
        if (wr_drop === 1'b1) dut_drops++;
        if (swap === 1'b1) dut_swaps++;
    endtask

    task automatic pixel(input bit nh, input bit nv, input int spacing);
        for (int i = 0; i < spacing; i++) begin
            pix_ce = (i == 0); nHBLANK = nh; nVBLANK = nv;
            if (rand_wr) begin
                wr_en   = ($urandom_range(0, 3) == 0);
                wr_x    = 9'($urandom_range(0, 319));
                wr_data = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            tick();
            if (i == 0) begin
                pix_swap0 = swap; pix_bank0 = rd_bank; pix_swap1 = 1'b0;
                if (last_rd_x >= 0) begin
                    obs_d[last_rd_x]   = int'(rd_data);
                    obs_v[last_rd_x]   = int'(rd_valid);
                    obs_b_d[last_rd_x] = int'(rd_data_b);
                    obs_b_v[last_rd_x] = int'(rd_valid_b);
                    exp_d[last_rd_x]   = exp_data;
                    exp_v[last_rd_x]   = exp_valid;
                end
            end
            if (i == 1) pix_swap1 = swap;
        end
        pix_ce = 1'b0;
        if (rand_wr) wr_en = 1'b0;
    endtask

    // Four blanking pixels, one pixel to resample nHBLANK high, then n_reads active pixels.
    task automatic line(input bit nv, input int spacing, input int n_reads);
        for (int x = 0; x < LW; x++) begin
            obs_d[x] = 0; obs_v[x] = 0; exp_d[x] = 0; exp_v[x] = 0; obs_b_d[x] = 0; obs_b_v[x] = 0;
        end
        for (int p = 0; p < 4; p++) begin
            pixel(1'b0, nv, spacing);
            if (p == 0) begin
                post_swap = pix_swap0; post_bank = pix_bank0; post_swap2 = pix_swap1;
            end
        end
        pixel(1'b1, nv, spacing);
        for (int r = 0; r < n_reads; r++) pixel(1'b1, nv, spacing);
    endtask

    task automatic wr(input int x, input int d);
        wr_en = 1'b1; wr_x = 9'(x); wr_data = 8'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_ce = 1'b0; wr_en = 1'b0; nHBLANK = 1'b1; nVBLANK = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK_48M);
        #1;
        rst = 1'b0;
    endtask

    function automatic int valid_count();
        int n = 0;
        for (int x = 0; x < LW; x++) n += obs_v[x];
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; model_reset();
        repeat (2) @(posedge CLK_48M);
        #1;
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        checks++; if (rd_x !== 9'd0) begin failures++; $display("FAIL reset_rd_x got=%0d exp=0", rd_x); end
        checks++; if (rd_bank !== 1'b0) begin failures++; $display("FAIL reset_rd_bank got=%0b exp=0", rd_bank); end
        checks++; if (swap !== 1'b0) begin failures++; $display("FAIL reset_swap got=%0b exp=0", swap); end
        checks++; if (wr_drop !== 1'b0) begin failures++; $display("FAIL reset_wr_drop got=%0b exp=0", wr_drop); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int ex;
        for (int i = 1; i <= 300; i++) begin
            pixel(1'b1, 1'b1, 8);
            ex = (i < LW - 1) ? i : LW - 1;
            checks++; if (rd_x !== 9'(ex)) begin failures++; $display("FAIL idle_rd_x i=%0d got=%0d exp=%0d", i, rd_x, ex); end
            checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
                failures++; $display("FAIL idle_pixel i=%0d got=%0h/%0b exp=0/0", i, rd_data, rd_valid);
            end
        end
    endtask

    task automatic test_single_pixel();
        wr(5, 8'h3A);
        checks++; if (wr_drop !== 1'b0) begin failures++; $display("FAIL single_nodrop got=%0b exp=0", wr_drop); end
        line(1'b1, 4, LW);
        checks++; if (post_swap !== 1'b1) begin failures++; $display("FAIL single_swap got=%0b exp=1", post_swap); end
        checks++; if (post_bank !== 1'b1) begin failures++; $display("FAIL single_bank got=%0b exp=1", post_bank); end
        checks++; if (post_swap2 !== 1'b0) begin failures++; $display("FAIL single_swap_width got=%0b exp=0", post_swap2); end
        checks++; if (obs_v[5] !== 1 || obs_d[5] !== 'h3A) begin
            failures++; $display("FAIL single_x5 got=%0h/%0d exp=3a/1", obs_d[5], obs_v[5]);
        end
        checks++; if (valid_count() !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", valid_count()); end
        line(1'b1, 4, LW);
        line(1'b1, 4, LW);
        checks++; if (obs_v[5] !== 0 || obs_d[5] !== 0) begin
            failures++; $display("FAIL single_cleared got=%0h/%0d exp=0/0", obs_d[5], obs_v[5]);
        end
    endtask

    task automatic test_first_wins();
        do_reset();
        wr(10, 8'h11);
        wr(10, 8'h22);
        line(1'b1, 4, LW);
        checks++; if (obs_d[10] !== 'h11 || obs_v[10] !== 1) begin
            failures++; $display("FAIL first_wins got=%0h/%0d exp=11/1", obs_d[10], obs_v[10]);
        end
        checks++; if (obs_b_d[10] !== 'h22 || obs_b_v[10] !== 1) begin
            failures++; $display("FAIL last_wins got=%0h/%0d exp=22/1", obs_b_d[10], obs_b_v[10]);
        end
    endtask

    task automatic test_drop();
        do_reset();
        wr(300, 8'h12);
        checks++; if (wr_drop !== 1'b1) begin failures++; $display("FAIL drop_range got=%0b exp=1", wr_drop); end
        wr(30, 8'h00);
        checks++; if (wr_drop !== 1'b0) begin failures++; $display("FAIL drop_transparent got=%0b exp=0", wr_drop); end
        nHBLANK = 1'b0; pix_ce = 1'b1; wr_en = 1'b1; wr_x = 9'd20; wr_data = 8'h55;
        tick();
        checks++; if (wr_drop !== 1'b1 || swap !== 1'b1) begin
            failures++; $display("FAIL drop_swap got=%0b/%0b exp=1/1", wr_drop, swap);
        end
        pix_ce = 1'b0; wr_en = 1'b0;
        tick();
        checks++; if (wr_drop !== 1'b0) begin failures++; $display("FAIL drop_pulse got=%0b exp=0", wr_drop); end
        line(1'b1, 4, LW);
        checks++; if (valid_count() !== 0) begin failures++; $display("FAIL drop_readout got=%0d exp=0", valid_count()); end
    endtask

    task automatic test_vblank();
        do_reset();
        wr(7, 8'h44);
        line(1'b0, 4, LW);
        checks++; if (obs_d[7] !== 0 || obs_v[7] !== 0) begin
            failures++; $display("FAIL vblank_mask got=%0h/%0d exp=0/0", obs_d[7], obs_v[7]);
        end
        line(1'b1, 4, LW);
        line(1'b1, 4, LW);
        checks++; if (obs_v[7] !== 0 || valid_count() !== 0) begin
            failures++; $display("FAIL vblank_cleared got=%0d/%0d exp=0/0", obs_v[7], valid_count());
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        wr(3, 8'h21);
        wr(200, 8'h22);
        line(1'b1, 4, 201);
        wr(4, 8'h31);
        checks++; if (rd_x !== 9'd201 || rd_bank !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'h22) begin
            failures++; $display("FAIL midline_pre got=%0d/%0b/%0b/%0h exp=201/1/1/22", rd_x, rd_bank, rd_valid, rd_data);
        end
        rst = 1'b1;
        #2;
        checks++; if (rd_x !== 9'd0 || rd_bank !== 1'b0) begin
            failures++; $display("FAIL midline_async_pos got=%0d/%0b exp=0/0", rd_x, rd_bank);
        end
        checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b0 || swap !== 1'b0 || wr_drop !== 1'b0) begin
            failures++; $display("FAIL midline_async_out got=%0h/%0b/%0b/%0b exp=0/0/0/0", rd_data, rd_valid, swap, wr_drop);
        end
        model_reset();
        repeat (2) @(posedge CLK_48M);
        #1;
        rst = 1'b0;
        line(1'b1, 4, LW);
        checks++; if (valid_count() !== 0) begin failures++; $display("FAIL midline_line1 got=%0d exp=0", valid_count()); end
        line(1'b1, 4, LW);
        checks++; if (valid_count() !== 0) begin failures++; $display("FAIL midline_line2 got=%0d exp=0", valid_count()); end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        rand_wr = 1'b1;
        for (int l = 0; l < 6; l++) begin
            line(($urandom_range(0, 3) != 0), int'($urandom_range(1, 5)), LW);
            bad = 0;
            for (int x = 0; x < LW; x++) begin
                checks++;
                if (obs_d[x] !== exp_d[x] || obs_v[x] !== exp_v[x]) begin
                    failures++; bad++;
                    if (bad <= 4) $display("FAIL random_pixel line=%0d x=%0d got=%0h/%0d exp=%0h/%0d",
                                           l, x, obs_d[x], obs_v[x], exp_d[x], exp_v[x]);
                end
            end
        end
        rand_wr = 1'b0;
        wr_en = 1'b0;
        checks++; if (dut_drops !== exp_drops) begin failures++; $display("FAIL random_drops got=%0d exp=%0d", dut_drops, exp_drops); end
        checks++; if (dut_swaps !== exp_swaps) begin failures++; $display("FAIL random_swaps got=%0d exp=%0d", dut_swaps, exp_swaps); end
        checks++; if (rd_x !== 9'(m_rx) || rd_bank !== 1'(m_rb)) begin
            failures++; $display("FAIL random_pos got=%0d/%0b exp=%0d/%0d", rd_x, rd_bank, m_rx, m_rb);
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_idle();
        test_single_pixel();
        test_first_wins();
        test_drop();
        test_vblank();
        test_reset_midline();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
